imem_responder: RTL and testbench

//  Memory-side responder for the cache refill interface (mem_req_valid/ready/addr/rdata).

---
 rtl/imem_responder_pkg.sv | 27 ++
 rtl/imem_word_ram.sv | 31 +++
 rtl/imem_responder.sv | 109 ++++++++++
 tb/tb_imem_responder.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_responder_pkg.sv
// Shared definitions for the instruction-memory responder: FSM encodings,
// the out-of-range fill word and the address window helpers.
package imem_responder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [1:0] ST_DROP = 2'd3;

    // RV32 NOP, so a stray fetch outside the array executes harmlessly
    localparam logic [31:0] OOB_WORD_DEFAULT = 32'h0000_0013;

    function automatic logic [31:0] word_offset(input logic [31:0] addr,
                                                input logic [31:0] base);
        return addr - base;
    endfunction

    // span is the window size in bytes; one bit wider so a 4 GiB window still fits
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [32:0] span);
        logic [31:0] off;
        off = addr - base;
        return (addr >= base) && ({1'b0, off} < span);
    endfunction

endpackage

// File: rtl/imem_word_ram.sv
// MEM_WORDS x 32 word array: one synchronous read port, one write port,
// read-before-write on a same-word collision. Only the read register resets.
module imem_word_ram #(
    parameter int          MEM_WORDS = 4096,
    parameter logic [31:0] FILL_WORD = 32'h0000_0013,
    parameter int          AW        = $clog2(MEM_WORDS)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          rd_en,
    input  logic          rd_fill,
    input  logic [AW-1:0] rd_idx,
    output logic [31:0]   rd_data,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_idx,
    input  logic [31:0]   wr_data
);

    logic [31:0] mem [MEM_WORDS];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= wr_data;
    end

    // rd_fill substitutes a fixed word so the output stays a plain register
    always_ff @(posedge clk) begin
        if (!resetn)    rd_data <= '0;
        else if (rd_en) rd_data <= rd_fill ? FILL_WORD : mem[rd_idx];
    end

endmodule

// File: rtl/imem_responder.sv
// Memory-side responder for the I-cache refill port: one word per request
// after a programmable wait, plus a preload write port into the word array.
module imem_responder
    import imem_responder_pkg::*;
#(
    parameter int          MEM_WORDS = 4096,
    parameter int          LATENCY   = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] OOB_WORD  = OOB_WORD_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_req_valid,
    output logic        mem_req_ready,
    input  logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_rdata,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    output logic        err_oob,
    output logic [31:0] req_count
);

    localparam int          AW   = $clog2(MEM_WORDS);
    localparam int          CW   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [32:0] SPAN = 33'(MEM_WORDS) << 2;
    localparam logic [CW-1:0] CNT_LOAD = CW'((LATENCY > 0) ? LATENCY - 1 : 0);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [31:0]   cap_addr;

    logic [31:0]   rd_addr, rd_off, ld_off;
    logic          rd_ok, ld_ok, enter_resp;
    logic          addr_bits_unused;

    // With zero latency the array is read on the accept edge, before cap_addr
    // is loaded, so the live address is used there; both are equal then.
    assign rd_addr = (state == ST_IDLE) ? mem_req_addr : cap_addr;
    assign rd_off  = word_offset(rd_addr, BASE_ADDR);
    assign ld_off  = word_offset(load_addr, BASE_ADDR);
    assign rd_ok   = in_window(rd_addr, BASE_ADDR, SPAN);
    assign ld_ok   = in_window(load_addr, BASE_ADDR, SPAN);

    assign addr_bits_unused = ^{rd_off[31:AW+2], rd_off[1:0],
                                ld_off[31:AW+2], ld_off[1:0]};

    assign enter_resp = mem_req_valid &&
                        (((state == ST_IDLE) && (LATENCY == 0)) ||
                         ((state == ST_WAIT) && (cnt == '0)));

    imem_word_ram #(
        .MEM_WORDS (MEM_WORDS),
        .FILL_WORD (OOB_WORD),
        .AW        (AW)
    ) u_ram (
        .clk     (clk),
        .resetn  (resetn),
        .rd_en   (enter_resp),
        .rd_fill (!rd_ok),
        .rd_idx  (rd_off[AW+1:2]),
        .rd_data (mem_req_rdata),
        .wr_en   (load_en && ld_ok),
        .wr_idx  (ld_off[AW+1:2]),
        .wr_data (load_data)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            cap_addr      <= '0;
            mem_req_ready <= 1'b0;
            err_oob       <= 1'b0;
            req_count     <= '0;
        end else begin
            mem_req_ready <= enter_resp;
            if (enter_resp) req_count <= req_count + 32'd1;
            if (load_en && !ld_ok) err_oob <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (mem_req_valid) begin
                        cap_addr <= mem_req_addr;
                        if (!rd_ok) err_oob <= 1'b1;
                        if (LATENCY == 0) begin
                            state <= ST_RESP;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= CNT_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    // valid dropping here is an abort: no response, no count
                    if (!mem_req_valid)   state <= ST_IDLE;
                    else if (cnt == '0)   state <= ST_RESP;
                    else                  cnt   <= cnt - 1'b1;
                end
                ST_RESP: state <= ST_DROP;
                // hold off until the cache lets go of valid, so a stale
                // valid cannot be taken as a second request
                ST_DROP: if (!mem_req_valid) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: directed table, hand-built corner
// sequences and randomized traffic against a word-array reference model.
module tb_imem_responder;

    localparam int          WORDS = 256;
    localparam int          LAT   = 2;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam logic [31:0] OOB   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_rdata;
    logic        load_en;
    logic [31:0] load_addr;
    logic [31:0] load_data;
    logic        err_oob;
    logic [31:0] req_count;

    imem_responder #(
        .MEM_WORDS (WORDS),
        .LATENCY   (LAT),
        .BASE_ADDR (BASE),
        .OOB_WORD  (OOB)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_req_rdata (mem_req_rdata),
        .load_en       (load_en),
        .load_addr     (load_addr),
        .load_data     (load_data),
        .err_oob       (err_oob),
        .req_count     (req_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // reference model: plain word array plus counters
    logic [31:0] m_mem [WORDS];
    logic [31:0] m_cnt;
    logic        m_err;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        bit          preload;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        return (a >= BASE) && ((a - BASE) < 32'(4 * WORDS));
    endfunction

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en   = 1'b0;
        if (in_rng(a)) m_mem[int'((a - BASE) >> 2)] = d;
        else           m_err = 1'b1;
    endtask

    // full cache-style handshake; valid held one cycle past the ready pulse
    task automatic request(input logic [31:0] a, input string nm);
        int          n;
        bit          seen;
        logic [31:0] exp;
        if (in_rng(a)) exp = m_mem[int'((a - BASE) >> 2)];
        else begin
            exp   = OOB;
            m_err = 1'b1;
        end
        mem_req_valid = 1'b1;
        mem_req_addr  = a;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            tick();
            n++;
            if (mem_req_ready) seen = 1'b1;
        end
        m_cnt = m_cnt + 32'd1;
        chk({nm, " latency"}, 32'(n), 32'(LAT + 1));
        chk({nm, " rdata"}, mem_req_rdata, exp);
        chk({nm, " count"}, req_count, m_cnt);
        chk({nm, " err"}, 32'(err_oob), 32'(m_err));
        tick();
        chk({nm, " pulse1"}, 32'(mem_req_ready), 32'd0);
        mem_req_valid = 1'b0;
        tick();
        chk({nm, " pulse2"}, 32'(mem_req_ready), 32'd0);
    endtask

    initial begin
        vec_t        tbl [6];
        int          pulses, start;
        logic [31:0] a;

        resetn        = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;
        load_en       = 1'b0;
        load_addr     = '0;
        load_data     = '0;
        m_cnt         = '0;
        m_err         = 1'b0;
        repeat (3) tick();
        chk("reset ready", 32'(mem_req_ready), 32'd0);
        chk("reset rdata", mem_req_rdata, 32'd0);
        chk("reset err", 32'(err_oob), 32'd0);
        chk("reset count", req_count, 32'd0);
        resetn = 1'b1;
        tick();

        for (int i = 0; i < WORDS; i++) load(BASE + 32'(4 * i), $urandom);

        tbl[0] = '{32'h0000_0014, 32'hDEAD_BEEF, 1'b1};
        tbl[1] = '{32'h0000_0000, 32'h0000_0A5A, 1'b1};
        tbl[2] = '{32'(4 * WORDS - 4), 32'hCAFE_F00D, 1'b1};
        tbl[3] = '{32'h0000_0017, 32'hDEAD_BEEF, 1'b0};
        tbl[4] = '{32'h0000_0020, 32'h1234_5678, 1'b1};
        tbl[5] = '{32'h0000_0021, 32'h1234_5678, 1'b0};
        for (int i = 0; i < 6; i++) begin
            if (tbl[i].preload) load(tbl[i].addr, tbl[i].data);
            request(tbl[i].addr, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d value", i), mem_req_rdata, tbl[i].data);
        end

        // 4-word line refill, back to back
        for (int i = 0; i < 4; i++) load(32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i));
        start = cyc;
        for (int i = 0; i < 4; i++) request(32'h100 + 32'(4 * i), $sformatf("line%0d", i));
        chk("line cycles", 32'(cyc - start), 32'(4 * (LAT + 3)));
        chk("line count", req_count, m_cnt);

        // abort after one wait cycle
        mem_req_valid = 1'b1;
        mem_req_addr  = 32'h0000_0030;
        tick();
        mem_req_valid = 1'b0;
        pulses = 0;
        repeat (6) begin
            tick();
            if (mem_req_ready) pulses++;
        end
        chk("abort pulses", 32'(pulses), 32'd0);
        chk("abort count", req_count, m_cnt);
        request(32'h0000_0008, "after abort");

        // out-of-range request, then sticky across legal traffic
        request(32'(4 * WORDS), "oob");
        chk("oob word", mem_req_rdata, 32'h0000_0013);
        request(32'h0000_0004, "legal1");
        request(32'h0000_0010, "legal2");
        chk("oob sticky", 32'(err_oob), 32'd1);

        // load collides with the response read of the same word
        load(32'h0000_000C, 32'h0000_1111);
        mem_req_valid = 1'b1;
        mem_req_addr  = 32'h0000_000C;
        tick();
        tick();
        load_en   = 1'b1;
        load_addr = 32'h0000_000C;
        load_data = 32'h0000_2222;
        tick();
        load_en = 1'b0;
        m_mem[3] = 32'h0000_2222;
        m_cnt    = m_cnt + 32'd1;
        chk("collide ready", 32'(mem_req_ready), 32'd1);
        chk("collide old", mem_req_rdata, 32'h0000_1111);
        tick();
        mem_req_valid = 1'b0;
        tick();
        request(32'h0000_000C, "collide new");
        chk("collide new value", mem_req_rdata, 32'h0000_2222);

        // randomized traffic
        for (int it = 0; it < 60; it++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 2) begin
                if ($urandom_range(0, 3) == 0) a = 32'(4 * WORDS) + 32'(4 * $urandom_range(0, 50));
                else a = BASE + 32'(4 * $urandom_range(0, WORDS - 1));
                load(a, $urandom);
            end else if (r == 2) begin
                mem_req_valid = 1'b1;
                mem_req_addr  = BASE + 32'(4 * $urandom_range(0, WORDS - 1));
                tick();
                mem_req_valid = 1'b0;
                pulses = 0;
                repeat (3) begin
                    tick();
                    if (mem_req_ready) pulses++;
                end
                chk($sformatf("rnd%0d abort", it), 32'(pulses), 32'd0);
            end else begin
                if ($urandom_range(0, 7) == 0) a = 32'(4 * WORDS) + 32'($urandom_range(0, 400));
                else a = BASE + 32'($urandom_range(0, 4 * WORDS - 1));
                request(a, $sformatf("rnd%0d", it));
            end
        end

        // reset while waiting
        mem_req_valid = 1'b1;
        mem_req_addr  = 32'h0000_0014;
        tick();
        resetn        = 1'b0;
        mem_req_valid = 1'b0;
        tick();
        chk("rst ready", 32'(mem_req_ready), 32'd0);
        chk("rst rdata", mem_req_rdata, 32'd0);
        chk("rst count", req_count, 32'd0);
        chk("rst err", 32'(err_oob), 32'd0);
        tick();
        chk("rst ready hold", 32'(mem_req_ready), 32'd0);
        resetn = 1'b1;
        m_cnt  = '0;
        m_err  = 1'b0;
        tick();
        request(32'h0000_0014, "post reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
